// File: rtl/dma_ctrl_pkg.sv
// Shared encodings for the DMA control configuration sequencer.
// State, response and error-code constants live here.
package dma_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BRESP = 2'd1;
    localparam logic [1:0] ERR_RRESP = 2'd2;
    localparam logic [1:0] ERR_DATA  = 2'd3;

    localparam int REG_STRIDE = 4;

endpackage

// File: rtl/axil_wr_channel_join.sv
// Joins the AXI4-Lite AW and W channels: each handshake is remembered
// independently so either channel may finish first.
module axil_wr_channel_join (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic aw_valid,
    input  logic aw_ready,
    input  logic w_valid,
    input  logic w_ready,
    output logic aw_done,
    output logic w_done,
    output logic both_done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (clr) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_valid && aw_ready) aw_done <= 1'b1;
            if (w_valid && w_ready)   w_done  <= 1'b1;
        end
    end

    assign both_done = aw_done & w_done;

endmodule

// File: rtl/dma_ctrl_cfg_sequencer.sv
// AXI4-Lite master that writes (and optionally reads back) a bank of
// configuration registers on a single start pulse.
module dma_ctrl_cfg_sequencer
    import dma_ctrl_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter int C_IDX_W = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               start,
    input  logic                               verify_en,
    input  logic [C_NUM_REGS*C_M_AXI_DATA_WIDTH-1:0] cfg_data,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [1:0]                         err_code,
    output logic [C_IDX_W-1:0]                 err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
    output logic [3:0]                         M_AXI_WSTRB,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [C_IDX_W-1:0] LAST_IDX = C_IDX_W'(C_NUM_REGS - 1);

    state_t state, state_nxt;

    logic [C_IDX_W-1:0]       idx;
    logic [C_NUM_REGS*DW-1:0] shadow;
    logic                     verify;
    logic [DW-1:0]            cur_data;
    logic [AW-1:0]            cur_addr;
    logic                     last;
    logic                     aw_done, w_done, both_done;
    logic                     in_wr;
    logic                     accept, advance, err_set;
    logic [1:0]               err_nxt;

    always_comb begin
        cur_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == C_IDX_W'(i)) cur_data = shadow[i*DW +: DW];
        end
    end

    assign cur_addr = C_BASE_ADDR + AW'(REG_STRIDE) * AW'(idx);
    assign last     = (idx == LAST_IDX);
    assign in_wr    = (state == ST_WR);

    axil_wr_channel_join u_join (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .clr       (in_wr && both_done),
        .aw_valid  (M_AXI_AWVALID),
        .aw_ready  (M_AXI_AWREADY),
        .w_valid   (M_AXI_WVALID),
        .w_ready   (M_AXI_WREADY),
        .aw_done   (aw_done),
        .w_done    (w_done),
        .both_done (both_done)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        err_set   = 1'b0;
        err_nxt   = ERR_NONE;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (both_done) state_nxt = ST_WRESP;
            end
            ST_WRESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_BRESP;
                        state_nxt = ST_DONE;
                    end else if (verify) begin
                        state_nxt = ST_RADDR;
                    end else if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARREADY) state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != RESP_OKAY) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_RRESP;
                        state_nxt = ST_DONE;
                    end else if (M_AXI_RDATA != cur_data) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_DATA;
                        state_nxt = ST_DONE;
                    end else if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx       <= '0;
            shadow    <= '0;
            verify    <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else begin
            if (accept) begin
                shadow    <= cfg_data;
                verify    <= verify_en;
                idx       <= '0;
                error     <= 1'b0;
                err_code  <= ERR_NONE;
                err_index <= '0;
            end
            if (advance) idx <= idx + 1'b1;
            if (err_set) begin
                error     <= 1'b1;
                err_code  <= err_nxt;
                err_index <= idx;
            end
        end
    end

    // VALIDs decode straight from state so an async reset drops them at once
    assign M_AXI_AWVALID = in_wr & ~aw_done;
    assign M_AXI_WVALID  = in_wr & ~w_done;
    assign M_AXI_AWADDR  = in_wr ? cur_addr : '0;
    assign M_AXI_WDATA   = in_wr ? cur_data : '0;
    assign M_AXI_BREADY  = (state == ST_WRESP);
    assign M_AXI_ARVALID = (state == ST_RADDR);
    assign M_AXI_ARADDR  = M_AXI_ARVALID ? cur_addr : '0;
    assign M_AXI_RREADY  = (state == ST_RDATA);
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hF;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_dma_ctrl_cfg_sequencer.sv
// Bench for dma_ctrl_cfg_sequencer: table of sequences against an
// AXI4-Lite slave model, plus latency, busy-start and reset cases.
module tb_dma_ctrl_cfg_sequencer;

    localparam int NR = 4;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            start = 1'b0;
    logic            verify_en = 1'b0;
    logic [NR*32-1:0] cfg_data = '0;
    logic            busy, done, error;
    logic [1:0]      err_code;
    logic [3:0]      err_index;
    logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    dma_ctrl_cfg_sequencer dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .verify_en(verify_en),
        .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int dly_a = 0, dly_b = 0, bfail = -1, rbad = -1, rrfail = -1;
    logic slv_clr = 1'b0;
    int aw_wait, w_wait, aw_beats, w_beats, ar_beats, b_cnt, done_cnt;
    logic got_aw, got_w;
    logic [31:0] wa_q, wd_q, wr_addr, wr_data;
    logic [31:0] mem [16];
    logic aw_hs, w_hs, ar_hs;
    logic [3:0] wr_ri, rd_ri;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= ((aw_beats % 2 == 0) ? dly_a : dly_b));
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= ((w_beats % 2 == 0) ? dly_b : dly_a));
    assign M_AXI_ARREADY = M_AXI_ARVALID;
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wr_addr = aw_hs ? M_AXI_AWADDR : wa_q;
    assign wr_data = w_hs ? M_AXI_WDATA : wd_q;
    assign wr_ri   = wr_addr[5:2];
    assign rd_ri   = M_AXI_ARADDR[5:2];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN || slv_clr) begin
            M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0;
            M_AXI_BRESP <= 2'b00; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
            got_aw <= 1'b0; got_w <= 1'b0; wa_q <= '0; wd_q <= '0;
            aw_wait <= 0; w_wait <= 0; aw_beats <= 0; w_beats <= 0;
            ar_beats <= 0; b_cnt <= 0; done_cnt <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (aw_hs) begin
                aw_wait <= 0; aw_beats <= aw_beats + 1;
                wa_q <= M_AXI_AWADDR; got_aw <= 1'b1;
            end else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
            if (w_hs) begin
                w_wait <= 0; w_beats <= w_beats + 1;
                wd_q <= M_AXI_WDATA; got_w <= 1'b1;
            end else if (M_AXI_WVALID) w_wait <= w_wait + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                mem[wr_ri] <= wr_data;
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP <= (b_cnt == bfail) ? 2'b10 : 2'b00;
                b_cnt <= b_cnt + 1;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (ar_hs) begin
                ar_beats <= ar_beats + 1;
                M_AXI_RVALID <= 1'b1;
                M_AXI_RDATA <= mem[rd_ri] ^ ((int'(rd_ri) == rbad) ? 32'h1 : 32'h0);
                M_AXI_RRESP <= (int'(rd_ri) == rrfail) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$];
    logic mon_en = 1'b0;
    logic p_aw_hs, p_w_hs, p_ar_hs, p_aw_wt, p_w_wt;

    always @(negedge ACLK) begin
        if (!mon_en) begin
            p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_aw_wt = 0; p_w_wt = 0;
        end else begin
            if (p_aw_hs) check("awvalid_drop", M_AXI_AWVALID, 0);
            if (p_w_hs)  check("wvalid_drop", M_AXI_WVALID, 0);
            if (p_ar_hs) check("arvalid_drop", M_AXI_ARVALID, 0);
            if (p_aw_wt) check("awvalid_hold", M_AXI_AWVALID, 1);
            if (p_w_wt)  check("wvalid_hold", M_AXI_WVALID, 1);
            if (aw_hs) begin
                check("aw_expected", exp_aw_q.size() != 0, 1);
                if (exp_aw_q.size() != 0) check("aw_addr", M_AXI_AWADDR, exp_aw_q.pop_front());
            end
            if (w_hs) begin
                check("w_expected", exp_w_q.size() != 0, 1);
                if (exp_w_q.size() != 0) check("w_data", M_AXI_WDATA, exp_w_q.pop_front());
            end
            if (ar_hs) begin
                check("ar_expected", exp_ar_q.size() != 0, 1);
                if (exp_ar_q.size() != 0) check("ar_addr", M_AXI_ARADDR, exp_ar_q.pop_front());
            end
            p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
            p_aw_wt = M_AXI_AWVALID && !M_AXI_AWREADY;
            p_w_wt  = M_AXI_WVALID && !M_AXI_WREADY;
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [127:0] cfg;
        bit           verify;
        int           da, db, bf, rb, rf;
        bit           e_err;
        logic [1:0]   e_code;
        logic [3:0]   e_idx;
        int           n_wr, n_rd;
    } vec_t;

    localparam logic [127:0] CFG_A = 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF;
    localparam logic [127:0] CFG_B = 128'h00000000_FFFFFFFF_12345678_80000001;

    vec_t vecs[7];

    task automatic slave_clear();
        slv_clr = 1'b1;
        @(negedge ACLK);
        slv_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit seen;
        dly_a = v.da; dly_b = v.db; bfail = v.bf; rbad = v.rb; rrfail = v.rf;
        slave_clear();
        for (int r = 0; r < v.n_wr; r++) begin
            exp_aw_q.push_back(32'(4 * r));
            exp_w_q.push_back(v.cfg[r*32 +: 32]);
        end
        for (int r = 0; r < v.n_rd; r++) exp_ar_q.push_back(32'(4 * r));
        start = 1'b1; verify_en = v.verify; cfg_data = v.cfg;
        @(negedge ACLK);
        start = 1'b0; verify_en = ~v.verify; cfg_data = ~v.cfg;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (done) seen = 1;
            else @(negedge ACLK);
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_error"}, error, v.e_err);
        check({tag, "_err_code"}, err_code, v.e_code);
        check({tag, "_err_index"}, err_index, v.e_idx);
        repeat (3) @(negedge ACLK);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_aw_beats"}, aw_beats, v.n_wr);
        check({tag, "_w_beats"}, w_beats, v.n_wr);
        check({tag, "_ar_beats"}, ar_beats, v.n_rd);
        check({tag, "_sb_left"}, exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        vecs[0] = '{cfg:CFG_A, verify:1, da:0, db:0, bf:-1, rb:-1, rf:-1,
                    e_err:0, e_code:0, e_idx:0, n_wr:4, n_rd:4};
        vecs[1] = '{cfg:CFG_A, verify:1, da:3, db:0, bf:-1, rb:-1, rf:-1,
                    e_err:0, e_code:0, e_idx:0, n_wr:4, n_rd:4};
        vecs[2] = '{cfg:CFG_A, verify:0, da:0, db:0, bf:2, rb:-1, rf:-1,
                    e_err:1, e_code:1, e_idx:2, n_wr:3, n_rd:0};
        vecs[3] = '{cfg:CFG_A, verify:1, da:0, db:0, bf:-1, rb:1, rf:-1,
                    e_err:1, e_code:3, e_idx:1, n_wr:2, n_rd:2};
        vecs[4] = '{cfg:CFG_B, verify:1, da:1, db:2, bf:-1, rb:-1, rf:3,
                    e_err:1, e_code:2, e_idx:3, n_wr:4, n_rd:4};
        vecs[5] = '{cfg:CFG_B, verify:0, da:0, db:0, bf:-1, rb:-1, rf:-1,
                    e_err:0, e_code:0, e_idx:0, n_wr:4, n_rd:0};
        vecs[6] = '{cfg:CFG_A, verify:1, da:0, db:0, bf:0, rb:-1, rf:-1,
                    e_err:1, e_code:1, e_idx:0, n_wr:1, n_rd:0};

        repeat (2) @(negedge ACLK);
        check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        check("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_err", {err_code, err_index}, 0);
        check("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        check("rst_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        check("rst_wstrb", M_AXI_WSTRB, 4'hF);
        ARESETN = 1'b1;
        @(negedge ACLK);
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Verify-off latency, inclusive of the start and done cycles, with a busy start
        dly_a = 0; dly_b = 0; bfail = -1; rbad = -1; rrfail = -1;
        slave_clear();
        for (int r = 0; r < NR; r++) begin
            exp_aw_q.push_back(32'(4 * r));
            exp_w_q.push_back(CFG_B[r*32 +: 32]);
        end
        start = 1'b1; verify_en = 1'b0; cfg_data = CFG_B;
        n = 1;
        while (!done && n < 100) begin
            @(negedge ACLK);
            n++;
            start = (n == 5);
            verify_en = (n == 5);
            if (n == 5) cfg_data = CFG_A;
        end
        start = 1'b0; verify_en = 1'b0;
        check("lat_cycles", n, 14);
        repeat (5) @(negedge ACLK);
        check("lat_busy_after", busy, 0);
        check("lat_aw_beats", aw_beats, 4);
        check("lat_ar_beats", ar_beats, 0);
        check("lat_done_pulses", done_cnt, 1);
        check("lat_error", error, 0);
        check("lat_sb_left", exp_aw_q.size() + exp_w_q.size(), 0);

        // Async reset while AWVALID is high
        mon_en = 1'b0;
        slave_clear();
        start = 1'b1; verify_en = 1'b1; cfg_data = CFG_A;
        @(negedge ACLK);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (M_AXI_AWVALID) seen = 1;
            else @(negedge ACLK);
        end
        check("rstmid_awvalid_seen", seen, 1);
        #1 ARESETN = 1'b0;
        #1;
        check("rstmid_awvalid", M_AXI_AWVALID, 0);
        check("rstmid_wvalid", M_AXI_WVALID, 0);
        check("rstmid_arvalid", M_AXI_ARVALID, 0);
        check("rstmid_busy", busy, 0);
        repeat (2) @(negedge ACLK);
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        ARESETN = 1'b1;
        @(negedge ACLK);
        mon_en = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_ctrl_cfg_sequencer.md
Name: dma_ctrl_cfg_sequencer

Overview:
- AXI4-Lite master that programs the MINIMAL_DMA_CONTROL slave register bank on one `start` pulse.
- Writes C_NUM_REGS words to consecutive word addresses starting at C_BASE_ADDR.
- When verification is enabled, reads each register back after writing it and compares the result.
- Sits between the processor-side configuration logic and the DMA control slave. It replaces hand-driven BFM register traffic in hardware.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_NUM_REGS, 4, number of registers to program (1..16).
- C_BASE_ADDR, 32'h0000_0000, byte address of register 0; register stride is 4.
- C_IDX_W, 4, width of the register index (ceil(log2(16))).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; ignored while busy
- verify_en  in  1  read-back-and-compare enable; sampled with start
- cfg_data  in  C_NUM_REGS*32  register values; register i is bits [32i+31:32i]; sampled with start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence (pass or fail)
- error  out  1  sticky fail flag; cleared by the next accepted start
- err_code  out  2  0 none, 1 BRESP not OKAY, 2 RRESP not OKAY, 3 data mismatch
- err_index  out  C_IDX_W  index of the failing register
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1  write-address valid
- M_AXI_AWREADY  in  1  write-address ready
- M_AXI_WDATA  out  32  write data
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1  write-data valid
- M_AXI_WREADY  in  1  write-data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write-response valid
- M_AXI_BREADY  out  1  write-response ready
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  read-address valid
- M_AXI_ARREADY  in  1  read-address ready
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read-data valid
- M_AXI_RREADY  out  1  read-data ready

Behaviour:
- Reset values:
  - All outputs 0, except AWPROT/ARPROT = 0 and WSTRB = 4'hF.
  - FSM in IDLE; idx = 0; cfg_data shadow register cleared.
- FSM states: IDLE, WR, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - On start, latch cfg_data and verify_en; clear error/err_code/err_index; set idx = 0; set busy.
  - Next cycle enters WR.
- WR (write address and data):
  - Assert AWVALID and WVALID together.
  - AWADDR = C_BASE_ADDR + 4*idx; WDATA = shadow[idx].
  - Drop AWVALID on the cycle after AW handshake; drop WVALID independently on the cycle after W handshake. Either channel may complete first, or both in the same cycle.
  - Once both handshakes are seen, go to WRESP.
  - VALID is never withdrawn before its handshake.
- WRESP:
  - BREADY = 1 in this state only.
  - On BVALID with BRESP != 00: error = 1, err_code = 1, err_index = idx, go to DONE.
  - On BVALID with OKAY: go to RADDR if verify_en, else to the next register.
- RADDR: ARVALID = 1, ARADDR = same address as the write. Hold until ARREADY, then go to RDATA.
- RDATA:
  - RREADY = 1.
  - On RVALID: if RRESP != 00, err_code = 2; else if RDATA != shadow[idx], err_code = 3.
  - Any error sets error and err_index = idx and goes to DONE.
  - Otherwise go to the next register.
- Next register: if idx == C_NUM_REGS-1 go to DONE; else idx += 1 and return to WR.
- DONE: pulse done for exactly 1 cycle, clear busy, return to IDLE.
- Abort policy: the sequence stops at the first error. Later registers are not written.
- Latency (zero-wait slave, verify off): 3 cycles per register plus 2 cycles of overhead.
- start while busy: ignored, with no effect on latched data.
- Reset mid-transaction: all VALIDs drop immediately (async). The slave is responsible for its own reset.
- An outstanding-transaction count above 1 is never generated.

Decomposition:
- Package dma_ctrl_pkg holds:
  - FSM state encoding;
  - RESP_OKAY = 2'b00;
  - ERR_* codes;
  - REG_STRIDE = 4.
- One sub-module, axil_wr_channel_join: tracks AW/W handshake completion independently and raises both_done. It is reusable by other AXI-Lite masters.

Test Plan:
- Verify on, zero-wait slave model; cfg = {0xBEEF0011, 0xDEAD0011, 0xABCD0001, 0x0101FFFF}:
  - Writes are seen at 0x0/0x4/0x8/0xC in that order.
  - Reads match; done pulses once; error = 0; total 4 writes + 4 reads.
- Slave asserts WREADY 3 cycles before AWREADY, then the reverse on the next register:
  - Each VALID drops one cycle after its own handshake.
  - No duplicate beats.
- Slave returns BRESP = 2'b10 on register 2: error = 1, err_code = 1, err_index = 2, no AW at 0xC, done pulses.
- Slave read-back of register 1 returns 0xABCD0000: err_code = 3, err_index = 1.
- Verify off, 4 registers:
  - No ARVALID ever.
  - done occurs 14 cycles after start with a zero-wait slave.
  - A second start during busy is ignored.
- ARESETN asserted while AWVALID is high: all VALIDs and busy are 0 in the same cycle. After release, a new start completes normally.
